// File: rtl/fifo_word_packer.sv
// Packs consecutive FIFO entries into one wide word for the next pipeline stage.
// A flush forces out a partially filled word together with its entry count.
module fifo_word_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int CNT_W          = $clog2(BYTES_PER_WORD + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic                                 rd_en,
  input  logic [DATA_WIDTH-1:0]                rd_data,
  input  logic                                 rd_val,
  input  logic                                 flush,
  output logic [BYTES_PER_WORD*DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]                     out_cnt,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int WORD_W = BYTES_PER_WORD * DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BYTES_PER_WORD);

  typedef enum logic [1:0] {FETCH, WAIT, OUT} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, out_cnt_next;
  logic [WORD_W-1:0] data_next;
  logic              valid_next;

  // out_data doubles as the assembly register, so a partial word carries zeros above its last entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      cnt       <= '0;
      out_data  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      out_data  <= data_next;
      out_cnt   <= out_cnt_next;
      out_valid <= valid_next;
    end
  end

  // The read strobe is a decode of the FETCH state, so the entry returns while the FSM sits in WAIT.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    data_next    = out_data;
    out_cnt_next = out_cnt;
    valid_next   = out_valid;
    rd_en        = 1'b0;
    case (state)
      FETCH: begin
        if (flush && cnt != '0) begin
          state_next   = OUT;
          valid_next   = 1'b1;
          out_cnt_next = cnt;
        end else begin
          rd_en      = ~reset;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (rd_val) begin
          data_next[cnt*DATA_WIDTH +: DATA_WIDTH] = rd_data;
          cnt_next = cnt + CNT_W'(1);
          if (cnt_next == FULL) begin
            state_next   = OUT;
            valid_next   = 1'b1;
            out_cnt_next = FULL;
          end else begin
            state_next = FETCH;
          end
        end else begin
          state_next = FETCH;
        end
      end
      OUT: begin
        if (out_ready) begin
          valid_next = 1'b0;
          cnt_next   = '0;
          data_next  = '0;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

endmodule
